wb_port_arbiter: RTL and testbench

Shares the single register-file write port between two sources: the in-order pipeline writeback from the MEM/WB stage outputs, and a multi-cycle execution unit (mul/div) that completes asynchronously to the pipeline. The pipeline always has priority. Multi-cycle results are held in a one-entry buffer and written in the first free writeback slot. If the buffer starves for too long, the block requests a pipeline stall to force a free slot.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/wb_mc_buffer.sv | 52 +++++
 rtl/wb_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the writeback-port arbiter and its result buffer.
package cpu_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_WAIT  = 2'd1,
      ARB_FORCE = 2'd2
   } arb_state_e;
endpackage

// File: rtl/wb_mc_buffer.sv
// One-entry holding register for a multi-cycle result awaiting a free writeback slot.
module wb_mc_buffer
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  capture,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  consume,
   input  logic                  invalidate,
   output logic                  valid,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [DATA_W-1:0]     data
);

   logic                  valid_q, valid_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0]     data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      data_d  = data_q;
      if (capture) begin
         valid_d = 1'b1;
         rd_d    = rd_in;
         data_d  = data_in;
      end else if (consume || invalidate) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign rd    = rd_q;
   assign data  = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (always first)
// and a buffered multi-cycle result, forcing a pipeline stall if the buffer starves.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | buffer empty, accepting a multi-cycle result
// ARB_WAIT  | result buffered, written on the first cycle without pipe write
// ARB_FORCE | starved too long; pipe_stall asserted until the result is written
module wb_port_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int XLEN       = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pipe_wb_en,
   input  logic [cpu_pkg::REG_ADDR_W-1:0] pipe_rd,
   input  logic [XLEN-1:0]                pipe_data,
   input  logic                           mc_valid,
   input  logic [cpu_pkg::REG_ADDR_W-1:0] mc_rd,
   input  logic [XLEN-1:0]                mc_data,
   output logic                           mc_ready,
   output logic                           rf_w_en,
   output logic [cpu_pkg::REG_ADDR_W-1:0] rf_w_addr,
   output logic [XLEN-1:0]                rf_w_data,
   output logic                           rf_w_src,
   output logic                           pipe_stall,
   output logic                           mc_drop
);
   import cpu_pkg::*;

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("wb_port_arbiter: STARVE_MAX must be within 1..15");
   end

   localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

   arb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  pipe_stall_q, pipe_stall_d;
   logic                  mc_drop_q, mc_drop_d;

   logic                  buf_valid;
   logic [REG_ADDR_W-1:0] buf_rd;
   logic [XLEN-1:0]       buf_data;
   logic                  buf_capture;
   logic                  buf_consume;
   logic                  buf_invalidate;

   logic                  pipe_we;
   logic                  buf_active;
   logic                  grant;
   logic                  waw;

   wb_mc_buffer #(
      .DATA_W (XLEN)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .capture    (buf_capture),
      .rd_in      (mc_rd),
      .data_in    (mc_data),
      .consume    (buf_consume),
      .invalidate (buf_invalidate),
      .valid      (buf_valid),
      .rd         (buf_rd),
      .data       (buf_data)
   );

   assign pipe_we    = pipe_wb_en && (pipe_rd != '0);
   assign buf_active = buf_valid && ((state_q == ARB_WAIT) || (state_q == ARB_FORCE));
   assign grant      = buf_active && !pipe_we;
   // A pipeline write to the same register is younger, so the buffered value is dead.
   assign waw        = buf_active && pipe_we && (pipe_rd == buf_rd);
   assign cnt_inc    = cnt_q + 1'b1;

   always_comb begin
      rf_w_en   = 1'b0;
      rf_w_addr = '0;
      rf_w_data = '0;
      rf_w_src  = 1'b0;
      if (!rst) begin
         if (pipe_we) begin
            rf_w_en   = 1'b1;
            rf_w_addr = pipe_rd;
            rf_w_data = pipe_data;
         end else if (buf_active) begin
            rf_w_en   = (buf_rd != '0);
            rf_w_addr = buf_rd;
            rf_w_data = buf_data;
            rf_w_src  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mc_drop_d      = 1'b0;
      buf_capture    = 1'b0;
      buf_consume    = 1'b0;
      buf_invalidate = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            cnt_d = '0;
            if (mc_valid) begin
               buf_capture = 1'b1;
               state_d     = ARB_WAIT;
            end
         end
         ARB_WAIT, ARB_FORCE: begin
            if (!buf_valid) begin
               state_d = ARB_IDLE;
               cnt_d   = '0;
            end else if (grant) begin
               buf_consume = 1'b1;
               mc_drop_d   = (buf_rd == '0);
               state_d     = ARB_IDLE;
               cnt_d       = '0;
            end else if (waw) begin
               buf_invalidate = 1'b1;
               mc_drop_d      = 1'b1;
               state_d        = ARB_IDLE;
               cnt_d          = '0;
            end else if (state_q == ARB_WAIT) begin
               cnt_d = cnt_inc;
               if (cnt_inc == STARVE_CNT) begin
                  state_d = ARB_FORCE;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
         end
      endcase
      pipe_stall_d = (state_d == ARB_FORCE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         cnt_q        <= '0;
         pipe_stall_q <= 1'b0;
         mc_drop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pipe_stall_q <= pipe_stall_d;
         mc_drop_q    <= mc_drop_d;
      end
   end

   assign mc_ready   = !rst && (state_q == ARB_IDLE);
   assign pipe_stall = pipe_stall_q;
   assign mc_drop    = mc_drop_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios plus a randomized run against a pending-result model of the arbiter.
module tb_wb_port_arbiter;
   localparam int XLEN       = 32;
   localparam int STARVE_MAX = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            pipe_wb_en;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_data;
   logic            mc_valid;
   logic [4:0]      mc_rd;
   logic [XLEN-1:0] mc_data;
   logic            mc_ready;
   logic            rf_w_en;
   logic [4:0]      rf_w_addr;
   logic [XLEN-1:0] rf_w_data;
   logic            rf_w_src;
   logic            pipe_stall;
   logic            mc_drop;

   int n_cmp  = 0;
   int n_fail = 0;

   wb_port_arbiter #(
      .STARVE_MAX (STARVE_MAX),
      .XLEN       (XLEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_wb_en (pipe_wb_en),
      .pipe_rd    (pipe_rd),
      .pipe_data  (pipe_data),
      .mc_valid   (mc_valid),
      .mc_rd      (mc_rd),
      .mc_data    (mc_data),
      .mc_ready   (mc_ready),
      .rf_w_en    (rf_w_en),
      .rf_w_addr  (rf_w_addr),
      .rf_w_data  (rf_w_data),
      .rf_w_src   (rf_w_src),
      .pipe_stall (pipe_stall),
      .mc_drop    (mc_drop)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pipe_wb_en = 1'b0;
      pipe_rd    = '0;
      pipe_data  = '0;
      mc_valid   = 1'b0;
      mc_rd      = '0;
      mc_data    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // {mc_ready, rf_w_en, pipe_stall, mc_drop}
   task automatic test_reset();
      idle_inputs();
      rst        = 1'b1;
      pipe_wb_en = 1'b1;
      pipe_rd    = 5'd4;
      pipe_data  = 32'h1234;
      mc_valid   = 1'b1;
      mc_rd      = 5'd6;
      tick();
      tick();
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en, pipe_stall, mc_drop} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_held: ready/wen/stall/drop got %b expected 0000",
                  {mc_ready, rf_w_en, pipe_stall, mc_drop});
      end
      rst = 1'b0;
      idle_inputs();
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en, pipe_stall, mc_drop, rf_w_addr, rf_w_data} !== {4'b1000, 5'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_after: ready/wen/stall/drop got %b addr %0d data %h expected 1000 0 0",
                  {mc_ready, rf_w_en, pipe_stall, mc_drop}, rf_w_addr, rf_w_data);
      end
      tick();
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en, mc_drop} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_no_capture: ready/wen/drop got %b expected 100",
                  {mc_ready, rf_w_en, mc_drop});
      end
   endtask

   task automatic test_idle_pipe();
      do_reset();
      mc_valid = 1'b1;
      mc_rd    = 5'd5;
      mc_data  = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en} !== 2'b10) begin
         n_fail++;
         $display("FAIL idle_capture_cycle: ready/wen got %b expected 10", {mc_ready, rf_w_en});
      end
      tick();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rf_w_en, rf_w_addr, rf_w_data, rf_w_src, mc_ready} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL idle_write: en %b addr %0d data %h src %b ready %b expected 1 5 deadbeef 1 0",
                  rf_w_en, rf_w_addr, rf_w_data, rf_w_src, mc_ready);
      end
      tick();
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en, mc_drop} !== 3'b100) begin
         n_fail++;
         $display("FAIL idle_after: ready/wen/drop got %b expected 100", {mc_ready, rf_w_en, mc_drop});
      end
   endtask

   task automatic test_contention();
      do_reset();
      pipe_wb_en = 1'b1;
      pipe_rd    = 5'd3;
      pipe_data  = 32'h11;
      mc_valid   = 1'b1;
      mc_rd      = 5'd7;
      mc_data    = 32'h77;
      #1;
      tick();
      mc_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         #1;
         n_cmp++;
         if ({rf_w_en, rf_w_addr, rf_w_data, rf_w_src, pipe_stall} !==
             {1'b1, 5'd3, 32'h11, 1'b0, (k >= 5)}) begin
            n_fail++;
            $display("FAIL contention_c%0d: en %b addr %0d data %h src %b stall %b expected 1 3 11 0 %b",
                     k, rf_w_en, rf_w_addr, rf_w_data, rf_w_src, pipe_stall, (k >= 5));
         end
         tick();
      end
      pipe_wb_en = 1'b0;
      #1;
      n_cmp++;
      if ({rf_w_en, rf_w_addr, rf_w_data, rf_w_src, pipe_stall} !== {1'b1, 5'd7, 32'h77, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL contention_grant: en %b addr %0d data %h src %b stall %b expected 1 7 77 1 1",
                  rf_w_en, rf_w_addr, rf_w_data, rf_w_src, pipe_stall);
      end
      tick();
      #1;
      n_cmp++;
      if ({pipe_stall, rf_w_en, mc_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL contention_release: stall/wen/ready got %b expected 001",
                  {pipe_stall, rf_w_en, mc_ready});
      end
   endtask

   task automatic test_waw();
      do_reset();
      mc_valid = 1'b1;
      mc_rd    = 5'd9;
      mc_data  = 32'h99;
      tick();
      idle_inputs();
      pipe_wb_en = 1'b1;
      pipe_rd    = 5'd9;
      pipe_data  = 32'h22;
      #1;
      n_cmp++;
      if ({rf_w_en, rf_w_addr, rf_w_data, rf_w_src} !== {1'b1, 5'd9, 32'h22, 1'b0}) begin
         n_fail++;
         $display("FAIL waw_pipe_write: en %b addr %0d data %h src %b expected 1 9 22 0",
                  rf_w_en, rf_w_addr, rf_w_data, rf_w_src);
      end
      tick();
      idle_inputs();
      #1;
      n_cmp++;
      if ({mc_drop, rf_w_en, mc_ready} !== 3'b101) begin
         n_fail++;
         $display("FAIL waw_drop: drop/wen/ready got %b expected 101", {mc_drop, rf_w_en, mc_ready});
      end
      tick();
      #1;
      n_cmp++;
      if ({mc_drop, rf_w_en} !== 2'b00) begin
         n_fail++;
         $display("FAIL waw_no_late_write: drop/wen got %b expected 00", {mc_drop, rf_w_en});
      end
   endtask

   task automatic test_rd_zero();
      do_reset();
      mc_valid = 1'b1;
      mc_rd    = 5'd0;
      mc_data  = 32'h55;
      tick();
      idle_inputs();
      #1;
      n_cmp++;
      if ({rf_w_en, rf_w_src, mc_ready, mc_drop} !== 4'b0100) begin
         n_fail++;
         $display("FAIL rd0_grant: wen/src/ready/drop got %b expected 0100",
                  {rf_w_en, rf_w_src, mc_ready, mc_drop});
      end
      tick();
      #1;
      n_cmp++;
      if ({rf_w_en, mc_ready, mc_drop} !== 3'b011) begin
         n_fail++;
         $display("FAIL rd0_drop: wen/ready/drop got %b expected 011", {rf_w_en, mc_ready, mc_drop});
      end
      tick();
      pipe_wb_en = 1'b1;
      pipe_rd    = 5'd0;
      pipe_data  = 32'hABCD;
      #1;
      n_cmp++;
      if ({rf_w_en, mc_drop, mc_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL rd0_pipe: wen/drop/ready got %b expected 001", {rf_w_en, mc_drop, mc_ready});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_force();
      int waited;
      do_reset();
      pipe_wb_en = 1'b1;
      pipe_rd    = 5'd3;
      pipe_data  = 32'h11;
      mc_valid   = 1'b1;
      mc_rd      = 5'd7;
      mc_data    = 32'h77;
      tick();
      mc_valid = 1'b0;
      waited   = 0;
      while (!pipe_stall && waited < 20) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (pipe_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL force_reach: stall %b after %0d cycles expected 1", pipe_stall, waited);
      end
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({pipe_stall, mc_ready, rf_w_en, mc_drop} !== 4'b0100) begin
         n_fail++;
         $display("FAIL force_reset: stall/ready/wen/drop got %b expected 0100",
                  {pipe_stall, mc_ready, rf_w_en, mc_drop});
      end
      tick();
      #1;
      n_cmp++;
      if ({rf_w_en, mc_drop, pipe_stall} !== 3'b000) begin
         n_fail++;
         $display("FAIL force_reset_after: wen/drop/stall got %b expected 000", {rf_w_en, mc_drop, pipe_stall});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mc_valid = 1'b1;
      mc_rd    = 5'd1;
      mc_data  = 32'h101;
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_c0: ready/wen got %b expected 10", {mc_ready, rf_w_en});
      end
      tick();
      mc_rd   = 5'd2;
      mc_data = 32'h202;
      #1;
      n_cmp++;
      if ({rf_w_en, rf_w_addr, rf_w_data, mc_ready} !== {1'b1, 5'd1, 32'h101, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_w1: en %b addr %0d data %h ready %b expected 1 1 101 0",
                  rf_w_en, rf_w_addr, rf_w_data, mc_ready);
      end
      tick();
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_c2: ready/wen got %b expected 10", {mc_ready, rf_w_en});
      end
      tick();
      mc_valid = 1'b0;
      #1;
      n_cmp++;
      if ({rf_w_en, rf_w_addr, rf_w_data, mc_ready} !== {1'b1, 5'd2, 32'h202, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_w2: en %b addr %0d data %h ready %b expected 1 2 202 0",
                  rf_w_en, rf_w_addr, rf_w_data, mc_ready);
      end
      tick();
      #1;
      n_cmp++;
      if ({mc_ready, rf_w_en} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_c4: ready/wen got %b expected 10", {mc_ready, rf_w_en});
      end
   endtask

   // Model: a single pending result with an age counting cycles it was blocked by the pipe.
   task automatic test_random();
      bit              m_valid = 1'b0;
      logic [4:0]      m_rd    = '0;
      logic [XLEN-1:0] m_data  = '0;
      int              m_age   = 0;
      bit              m_drop  = 1'b0;
      bit              pwe;
      bit              nxt_drop;
      logic [41:0]     exp_v;
      logic [41:0]     got_v;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         pipe_wb_en = ($urandom_range(0, 9) < 6);
         pipe_rd    = 5'($urandom_range(0, 7));
         pipe_data  = $urandom;
         mc_valid   = ($urandom_range(0, 1) == 1);
         mc_rd      = 5'($urandom_range(0, 7));
         mc_data    = $urandom;
         #1;
         pwe = pipe_wb_en && (pipe_rd != 0);
         if (pwe)
            exp_v = {1'b1, pipe_rd, pipe_data, 1'b0, 3'b000};
         else if (m_valid)
            exp_v = {(m_rd != 0), m_rd, m_data, 1'b1, 3'b000};
         else
            exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 3'b000};
         exp_v[2] = !m_valid;
         exp_v[1] = m_valid && (m_age >= STARVE_MAX);
         exp_v[0] = m_drop;
         got_v = {rf_w_en, rf_w_addr, rf_w_data, rf_w_src, mc_ready, pipe_stall, mc_drop};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL random_c%0d: en/addr/data/src/ready/stall/drop got %h expected %h",
                     cyc, got_v, exp_v);
         end
         nxt_drop = 1'b0;
         if (m_valid) begin
            if (!pwe) begin
               m_valid  = 1'b0;
               nxt_drop = (m_rd == 0);
            end else if (pipe_rd == m_rd) begin
               m_valid  = 1'b0;
               nxt_drop = 1'b1;
            end else begin
               m_age++;
            end
         end else if (mc_valid) begin
            m_valid = 1'b1;
            m_rd    = mc_rd;
            m_data  = mc_data;
            m_age   = 0;
         end
         m_drop = nxt_drop;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_idle_pipe();
      test_contention();
      test_waw();
      test_rd_zero();
      test_reset_force();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
